// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: BUBBLE/RUN/SLOT FSM; outputs update one edge after inputs.
// Stalls (le=0) freeze PC/nPC/state and park a late-arriving transfer until le returns.
module fetch_pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        le,
    input  logic        taken,
    input  logic [31:0] target,
    output logic [31:0] pc_out,
    output logic [31:0] npc_out,
    output logic        fetch_valid,
    output logic        delay_slot,
    output logic        misalign_err,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        RUN    = 2'd1,
        SLOT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        misalign_q, misalign_d;
    logic [15:0] cnt_q, cnt_d;

    logic        advance;
    logic        eff_taken;
    logic [31:0] eff_target;
    logic        accept;

    // A transfer seen during a stall is parked so it is not lost when le returns.
    assign advance    = (state_q != BUBBLE) && le;
    assign eff_taken  = taken || pend_vld_q;
    assign eff_target = taken ? target : pend_tgt_q;
    assign accept     = advance && eff_taken;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            BUBBLE: begin
                state_d = RUN;
            end
            RUN, SLOT: begin
                if (accept) begin
                    pc_d    = npc_q;
                    npc_d   = {eff_target[31:2], 2'b00};
                    state_d = SLOT;
                end else if (advance) begin
                    pc_d    = npc_q;
                    npc_d   = npc_q + 32'd4;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BUBBLE;
            end
        endcase

        if (accept) begin
            pend_vld_d = 1'b0;
            if (eff_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (!le && taken) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BUBBLE;
            pc_q       <= 32'h0000_0000;
            npc_q      <= 32'h0000_0004;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
            misalign_q <= 1'b0;
            cnt_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_out         = pc_q;
    assign npc_out        = npc_q;
    assign fetch_valid    = (state_q != BUBBLE);
    assign delay_slot     = (state_q == SLOT);
    assign misalign_err   = misalign_q;
    assign redirect_count = cnt_q;

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and reset.
REQ-002 clk  input  1  pipeline clock.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 le  input  1  load enable from the hazard unit; 0 = stall, hold PC/nPC.
REQ-005 taken  input  1  control-transfer select from the branch logic; 1 = redirect to target.
REQ-006 target  input  32  selected target address (ID_TA, EX_TA or register value), qualified by taken.
REQ-007 pc_out  output  32  address of the instruction being fetched.
REQ-008 npc_out  output  32  next fetch address; feeds the not-taken leg of the branch mux.
REQ-009 fetch_valid  output  1  1 = pc_out is a real fetch; 0 during the post-reset bubble.
REQ-010 delay_slot  output  1  1 = the instruction at pc_out is the delay slot of an accepted transfer.
REQ-011 misalign_err  output  1  sticky flag; an accepted target had target[1:0] != 00.
REQ-012 redirect_count  output  16  saturating count of accepted transfers.

Function
REQ-013 State machine states SHALL be BUBBLE, RUN and SLOT, encoded in 2 bits.
REQ-014 BUBBLE -> RUN on the first rising edge after reset deasserts, regardless of le; pc_out and npc_out SHALL NOT change on that edge.
REQ-015 A transfer SHALL be accepted only on an edge where the state is RUN or SLOT, le=1, and an effective taken is present.
REQ-016 Accepted edge: pc_out <= npc_out; npc_out <= {target[31:2],2'b00}; state -> SLOT.
REQ-017 Sequential edge: the state is RUN or SLOT, le=1, and no transfer is accepted. On this edge pc_out <= npc_out, npc_out <= npc_out+4 modulo 2^32, and state -> RUN.
REQ-018 le=0 SHALL hold pc_out, npc_out, state and delay_slot unchanged.
REQ-019 If taken=1 while le=0, the module SHALL latch target into a pending register and set pending_valid.
REQ-020 A later taken=1 arriving while le=0 SHALL overwrite the pending target.
REQ-021 Effective taken SHALL be taken OR pending_valid.
REQ-022 Effective target SHALL be the live target if taken=1, otherwise the pending target.
REQ-023 pending_valid SHALL clear on the accepting edge.
REQ-024 delay_slot SHALL equal 1 exactly when the state is SLOT.
REQ-025 A transfer accepted while in SLOT (transfer in a delay slot) SHALL follow REQ-016 and remain in SLOT.
REQ-026 misalign_err SHALL set on an accepting edge whose effective target[1:0] != 00, and SHALL clear only on reset.
REQ-027 redirect_count SHALL increment by 1 per accepted transfer and saturate at 16'hFFFF.
REQ-028 npc_out = 32'hFFFF_FFFC on a sequential edge SHALL wrap to 32'h0000_0000 without error.
REQ-029 fetch_valid SHALL be 0 in BUBBLE and 1 in RUN and SLOT.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 On reset assertion, the module SHALL asynchronously set: pc_out=32'h0, npc_out=32'h4, state=BUBBLE, fetch_valid=0, delay_slot=0, pending_valid=0, misalign_err=0, redirect_count=0.
REQ-032 Reset asserted mid-stall or in SLOT SHALL discard any pending transfer.
REQ-033 After reset deasserts, sequencing SHALL restart per REQ-014.

Verification
REQ-034 Sequential fetch: reset, then le=1, taken=0 for 4 edges -> edge 1 BUBBLE->RUN with pc=0; edges 2-4 give pc=4, 8, 12; npc always pc+4; delay_slot=0.
REQ-035 Taken transfer: in RUN with pc=8, npc=12, drive taken=1, target=32'h100 -> next pc=12, npc=32'h100, delay_slot=1, redirect_count=1; the following sequential edge gives pc=32'h100, npc=32'h104, delay_slot=0.
REQ-036 Stall capture: le=0 with taken=1, target=32'h200 for one cycle, then taken=0, le=0 for 2 cycles, then le=1 -> pc/npc frozen while stalled; on the le=1 edge npc=32'h200, delay_slot=1, pending cleared.
REQ-037 Misalign and back-to-back: in SLOT, accept target=32'h302 -> npc=32'h300, state stays SLOT, misalign_err=1, and misalign_err stays 1 through 10 more edges.
REQ-038 Wrap and saturation: force npc=32'hFFFF_FFFC and take a sequential edge -> npc=0. Preload redirect_count=16'hFFFF and accept one transfer -> count stays 16'hFFFF.
REQ-039 Async reset: assert reset between clock edges while in SLOT with pending_valid=1 -> all outputs at REQ-031 values immediately, before the next edge.
